// File: rtl/kgp_isa_pkg.sv
// KGP miniRISC ISA constants shared by the fetch/PC logic.
// Holds the opcode map, the sequencer state encoding and the default reset PC.
package kgp_isa_pkg;

    localparam logic [5:0] OP_B    = 6'b101000;
    localparam logic [5:0] OP_BR   = 6'b100000;
    localparam logic [5:0] OP_BLTZ = 6'b110000;
    localparam logic [5:0] OP_BZ   = 6'b110001;
    localparam logic [5:0] OP_BNZ  = 6'b110010;
    localparam logic [5:0] OP_BL   = 6'b101011;
    localparam logic [5:0] OP_BCY  = 6'b101001;
    localparam logic [5:0] OP_BNCY = 6'b101010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [31:0] KGP_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    // b, bl, bcy and bncy carry a 26-bit word offset.
    function automatic logic is_long_branch(input logic [5:0] op);
        return (op == OP_B) || (op == OP_BL) || (op == OP_BCY) || (op == OP_BNCY);
    endfunction

    function automatic logic is_short_branch(input logic [5:0] op);
        return (op == OP_BLTZ) || (op == OP_BZ) || (op == OP_BNZ);
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative or register-indirect.
// Unconditional branches (b, br, bl) take their target regardless of branch_taken.
module next_pc_calc
    import kgp_isa_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       instr,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] rs_value,
    output logic [ADDR_W-1:0] next_pc
);

    logic [5:0]        op;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] off26;
    logic [ADDR_W-1:0] off16;
    logic [ADDR_W-1:0] rs_aligned;
    logic              uncond;
    logic              take;

    assign op         = instr[31:26];
    assign seq        = pc + ADDR_W'(4);
    assign off26      = {{(ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};
    assign off16      = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    assign rs_aligned = rs_value & ~ADDR_W'(3);
    assign uncond     = (op == OP_B) || (op == OP_BR) || (op == OP_BL);
    assign take       = branch_taken || uncond;

    always_comb begin
        next_pc = seq;
        if (take) begin
            if (op == OP_BR) begin
                next_pc = rs_aligned;
            end else if (is_long_branch(op)) begin
                next_pc = seq + off26;
            end else if (is_short_branch(op)) begin
                next_pc = seq + off16;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the KGP miniRISC core: fetch FSM, instruction latch,
// PC update on exec_done and the ra link write for bl.
module pc_sequencer
    import kgp_isa_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(KGP_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [5:0]        opcode,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] rs_value,
    input  logic              exec_done,
    output logic [ADDR_W-1:0] pc,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_data,
    output logic              halted,
    output state_t            dbg_state
);

    // Fetch handshake: imem_req rises on leaving FETCH and stays high with
    // imem_addr stable until the cycle imem_ack is seen in WAIT; imem_rdata is
    // taken in that same cycle. Acks in any other state are dropped.

    state_t            state;
    logic [ADDR_W-1:0] next_pc;

    assign imem_addr = pc;
    assign opcode    = instr[31:26];
    assign dbg_state = state;

    next_pc_calc #(
        .ADDR_W(ADDR_W)
    ) u_next_pc (
        .pc          (pc),
        .instr       (instr),
        .branch_taken(branch_taken),
        .rs_value    (rs_value),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            link_we     <= 1'b0;
            link_data   <= '0;
            halted      <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            link_we     <= 1'b0;
            case (state)
                FETCH: begin
                    imem_req <= 1'b1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        // halt freezes pc at the address of the halt itself
                        if (opcode == OP_HALT) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= FETCH;
                            if (opcode == OP_BL) begin
                                link_we   <= 1'b1;
                                link_data <= pc + ADDR_W'(4);
                            end
                        end
                    end
                end
                HALT: begin
                    imem_req <= 1'b0;
                    halted   <= 1'b1;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: driver tasks push expected instr/pc/link
// values into queues; a negedge monitor pops and compares on DUT events.
module tb_pc_sequencer;
    import kgp_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic        branch_taken;
    logic [31:0] rs_value;
    logic        exec_done;
    logic [31:0] pc;
    logic        link_we;
    logic [31:0] link_data;
    logic        halted;
    state_t      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_link_q[$];
    logic [31:0] model_pc;

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .branch_taken(branch_taken),
        .rs_value    (rs_value),
        .exec_done   (exec_done),
        .pc          (pc),
        .link_we     (link_we),
        .link_data   (link_data),
        .halted      (halted),
        .dbg_state   (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    state_t prev_state = FETCH;
    logic   prev_rst   = 1'b1;
    logic   prev_iv    = 1'b0;
    logic   prev_lw    = 1'b0;

    always @(negedge clk) begin
        if (!prev_rst) begin
            if (instr_valid) begin
                check("instr_valid_single", {31'b0, prev_iv}, 32'd0);
                if (exp_instr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL instr_unexpected: got %h with no fetch pending", instr);
                end else begin
                    check("instr_latched", instr, exp_instr_q.pop_front());
                end
            end
            if (prev_state == EXEC && dbg_state != EXEC) begin
                if (exp_pc_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pc_unexpected: got %h with no exec_done pending", pc);
                end else begin
                    check("pc_update", pc, exp_pc_q.pop_front());
                end
            end
            if (link_we) begin
                check("link_we_single", {31'b0, prev_lw}, 32'd0);
                if (exp_link_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL link_unexpected: got %h with no bl pending", link_data);
                end else begin
                    check("link_data", link_data, exp_link_q.pop_front());
                end
            end
        end
        prev_rst   = rst;
        prev_state = dbg_state;
        prev_iv    = instr_valid;
        prev_lw    = link_we;
    end

    // ---------------- driver ----------------
    task automatic run_instr(input logic [31:0] word, input logic taken, input logic [31:0] rs,
                             input int ack_dly, input int done_dly,
                             input logic [31:0] exp_pc, input logic is_bl);
        check("fetch_state", 32'(dbg_state), 32'(FETCH));
        tick();
        for (int i = 0; i <= ack_dly; i++) begin
            check("wait_state", 32'(dbg_state), 32'(WAIT));
            check("wait_req", {31'b0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, model_pc);
            if (i == ack_dly) begin
                imem_ack   = 1'b1;
                imem_rdata = word;
                exp_instr_q.push_back(word);
            end
            tick();
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
        end
        for (int i = 0; i <= done_dly; i++) begin
            check("exec_instr", instr, word);
            check("exec_opcode", {26'b0, opcode}, {26'b0, word[31:26]});
            check("exec_req_low", {31'b0, imem_req}, 32'd0);
            if (i == done_dly) begin
                exec_done    = 1'b1;
                branch_taken = taken;
                rs_value     = rs;
                exp_pc_q.push_back(exp_pc);
                if (is_bl) exp_link_q.push_back(model_pc + 32'd4);
            end else begin
                branch_taken = 1'($urandom_range(0, 1));
                rs_value     = $urandom;
            end
            tick();
            exec_done    = 1'b0;
            branch_taken = 1'($urandom_range(0, 1));
            rs_value     = $urandom;
        end
        model_pc = exp_pc;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        branch_taken = 1'b0;
        rs_value     = 32'h0;
        exec_done    = 1'b0;
        model_pc     = 32'h0;
        repeat (2) tick();

        check("rst_state", 32'(dbg_state), 32'(FETCH));
        check("rst_pc", pc, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_link_we", {31'b0, link_we}, 32'd0);
        check("rst_link_data", link_data, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        rst = 1'b0;

        //        word          tk    rs            ack dn  expected pc   bl
        run_instr(32'h0000_0123, 1'b0, 32'h0,        2,  1,  32'h0000_0004, 1'b0); // add
        run_instr(32'hA000_003E, 1'b1, 32'h0,        0,  0,  32'h0000_0100, 1'b0); // b +0xF8
        run_instr(32'hC6AB_0003, 1'b1, 32'h0,        1,  0,  32'h0000_0110, 1'b0); // bz taken
        run_instr(32'hA3FF_FFFB, 1'b1, 32'h0,        0,  1,  32'h0000_0100, 1'b0); // b -0x14
        run_instr(32'hC6AB_0003, 1'b0, 32'h0,        0,  0,  32'h0000_0104, 1'b0); // bz not taken
        run_instr(32'hA000_003E, 1'b1, 32'h0,        1,  1,  32'h0000_0200, 1'b0); // b +0xF8
        run_instr(32'hAFFF_FFFF, 1'b1, 32'h0,        0,  2,  32'h0000_0200, 1'b1); // bl -4
        run_instr(32'h8000_0000, 1'b1, 32'h0000_1237, 0, 0,  32'h0000_1234, 1'b0); // br
        run_instr(32'h8000_0000, 1'b1, 32'hFFFF_FFFC, 0, 0,  32'hFFFF_FFFC, 1'b0); // br
        run_instr(32'h0000_0055, 1'b1, 32'h0,        1,  0,  32'h0000_0000, 1'b0); // wrap
        run_instr(32'hA400_0010, 1'b1, 32'h0,        0,  0,  32'h0000_0044, 1'b0); // bcy taken
        run_instr(32'hA800_0020, 1'b0, 32'h0,        0,  0,  32'h0000_0048, 1'b0); // bncy not taken
        run_instr(32'hC000_FFFF, 1'b1, 32'h0,        0,  0,  32'h0000_0048, 1'b0); // bltz -4
        run_instr(32'hC800_0007, 1'b0, 32'h0,        0,  0,  32'h0000_004C, 1'b0); // bnz not taken

        // spurious ack and exec_done in FETCH
        imem_ack     = 1'b1;
        imem_rdata   = 32'hDEAD_BEEF;
        exec_done    = 1'b1;
        branch_taken = 1'b1;
        tick();
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        check("spur_state", 32'(dbg_state), 32'(WAIT));
        check("spur_instr", instr, 32'hC800_0007);
        check("spur_pc", pc, 32'h0000_004C);
        check("spur_valid", {31'b0, instr_valid}, 32'd0);

        // reset in WAIT with a colliding ack
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        tick();
        rst      = 1'b0;
        imem_ack = 1'b0;
        model_pc = 32'h0;
        check("wrst_state", 32'(dbg_state), 32'(FETCH));
        check("wrst_pc", pc, 32'h0);
        check("wrst_instr", instr, 32'h0);
        check("wrst_req", {31'b0, imem_req}, 32'd0);
        check("wrst_link_data", link_data, 32'h0);

        // halt and recovery
        run_instr(32'h0000_0001, 1'b0, 32'h0, 0, 0, 32'h0000_0004, 1'b0);
        run_instr(32'hFC00_0000, 1'b1, 32'h0, 0, 1, 32'h0000_0004, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("halt_state", 32'(dbg_state), 32'(HALT));
            check("halt_req", {31'b0, imem_req}, 32'd0);
            check("halt_pc", pc, 32'h0000_0004);
            check("halt_flag", {31'b0, halted}, 32'd1);
            imem_ack  = 1'(i % 2);
            exec_done = 1'(i % 3 == 0);
            tick();
        end
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("hrst_pc", pc, 32'h0);
        check("hrst_halted", {31'b0, halted}, 32'd0);
        check("hrst_state", 32'(dbg_state), 32'(FETCH));
        tick();
        tick();

        check("instr_q_drained", exp_instr_q.size(), 32'd0);
        check("pc_q_drained", exp_pc_q.size(), 32'd0);
        check("link_q_drained", exp_link_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter of the KGP miniRISC core.
- Fetches instructions over a req/ack instruction-memory handshake and presents them to decode.
- Consumes the branch-taken decision produced by branch_control, and from it and the current opcode selects the next PC: sequential, PC-relative, or register-indirect.
- Sits between instruction memory and the decode/execute datapath; also produces the link write for bl.

Parameters:
- ADDR_W, 32, PC and instruction-address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch byte address; equals pc.
- imem_ack  in  1  memory response valid; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  latched instruction presented to decode.
- instr_valid  out  1  one-cycle pulse when instr is updated.
- opcode  out  6  instr[31:26], fed to branch_control.
- branch_taken  in  1  branch_control out; sampled only in EXEC on exec_done.
- rs_value  in  ADDR_W  register rs value, the target for br.
- exec_done  in  1  execute/memory stage finished for the current instruction.
- pc  out  ADDR_W  current PC.
- link_we  out  1  one-cycle write-enable for ra (r31).
- link_data  out  ADDR_W  return address, pc+4.
- halted  out  1  high once the halt opcode has executed.

Behaviour:
- Reset values: state=FETCH, pc=RESET_PC, imem_req=0, instr=0, instr_valid=0, link_we=0, link_data=0, halted=0.
- Reset is taken on any cycle, including mid-fetch or in HALT. An outstanding request is abandoned, and an ack arriving in the reset cycle is ignored.
- States and transitions:
  - FETCH: assert imem_req, go to WAIT.
  - WAIT: keep imem_req=1 with imem_addr stable. On imem_ack: latch instr, pulse instr_valid, drop imem_req, go to EXEC.
  - EXEC: hold instr. Wait for exec_done; on exec_done, update pc and go to FETCH, or go to HALT if opcode==OP_HALT.
  - HALT: imem_req=0, halted=1, pc frozen; exits only on rst.
- imem_ack outside WAIT is ignored.
- Fetch latency: minimum 3 cycles per instruction (FETCH, WAIT with ack in the same cycle, EXEC with exec_done in the same cycle).
- Next-PC rule on exec_done: seq = pc+4, modulo 2^ADDR_W, so it wraps.
  - Opcodes b, bl, bcy, bncy: offset = sext(instr[25:0])<<2.
  - Opcodes bltz, bz, bnz: offset = sext(instr[15:0])<<2.
  - If the opcode is in the branch class and branch_taken=1:
    - br: next = {rs_value[ADDR_W-1:2], 2'b00} (low bits forced to zero).
    - All others: next = seq + offset, modulo 2^ADDR_W.
  - Otherwise next = seq.
  - For b, br and bl the target is used whatever branch_taken says, because branch_control asserts taken for these opcodes. The bench checks that agreement.
- bl: on the same edge that pc updates, link_we pulses high for one cycle with link_data = old pc+4.
- branch_taken and rs_value are don't-care outside the EXEC&&exec_done cycle.
- exec_done in any state other than EXEC is ignored.
- instr_valid and link_we never stay high more than one cycle.

Decomposition:
- Shared package kgp_isa_pkg holds:
  - opcode localparams: OP_B=101000, OP_BR=100000, OP_BLTZ=110000, OP_BZ=110001, OP_BNZ=110010, OP_BL=101011, OP_BCY=101001, OP_BNCY=101010, OP_HALT=111111;
  - state encodings FETCH/WAIT/EXEC/HALT;
  - RESET_PC default.
- One natural sub-module, next_pc_calc: combinational, from pc, instr, branch_taken and rs_value to next_pc. The FSM and registers remain in pc_sequencer.

Test Plan:
- Reset then ack 2 cycles late, with instr = add (opcode 000000) and exec_done at cycle 1 of EXEC:
  - imem_addr=0 held over the WAIT cycles; instr_valid pulses once; pc becomes 4.
- pc=0x100, bz (110001) with imm16=0x0003, branch_taken=1 → pc=0x110. Same with branch_taken=0 → pc=0x104.
- pc=0x200, bl with imm26=0x3FFFFFF (offset -4) → pc=0x200; link_we pulses for one cycle with link_data=0x204.
- br with rs_value=0x0000_1237, branch_taken=1 → pc=0x1234. Also: pc=0xFFFF_FFFC with a non-branch instruction → pc wraps to 0x0.
- Boundary and mid-operation cases:
  - rst asserted while in WAIT with imem_ack in the same cycle → next cycle pc=RESET_PC, instr unchanged (0), imem_req low.
  - Spurious imem_ack or exec_done in FETCH → no state change.
- OP_HALT with exec_done → halted=1, imem_req stays 0 for 20 cycles, pc frozen; rst → pc=RESET_PC, halted=0.
